// File: rtl/dcache_wr_arbiter_pkg.sv
// Shared types for the data-side write arbiter: FSM states, owner
// encoding and the default uncached-streak limit.
package dcache_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_B = 2'd2
  } dcache_wr_arb_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    FIFO = 2'd1,
    UC   = 2'd2
  } wr_owner_t;

  localparam int DCACHE_WR_MAX_UC_STREAK = 4;
  localparam int DCACHE_WR_LINE_WIDTH    = 128;

endpackage

// File: rtl/dcache_wr_arbiter.sv
// Shares the single AXI write-request port between the dcache write-back
// FIFO (full lines) and the uncached-store path (single words). One write
// is in flight at a time: request -> accept -> bvalid. The uncached path
// is favoured, but only for MAX_UC_STREAK grants in a row while the FIFO
// is waiting, and never while a drain is requested.
module dcache_wr_arbiter
  import dcache_wr_arbiter_pkg::*;
#(
  parameter int DCACHELINE_WIDTH = DCACHE_WR_LINE_WIDTH,
  parameter int MAX_UC_STREAK    = DCACHE_WR_MAX_UC_STREAK
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fifo_wen_i,
  input  logic [31:0]                   fifo_awaddr_i,
  input  logic [DCACHELINE_WIDTH-1:0]   fifo_wdata_i,
  input  logic                          fifo_full_i,
  input  logic                          fifo_empty_i,
  output logic                          fifo_req_accept_o,
  output logic                          fifo_bvalid_o,
  input  logic                          uc_wen_i,
  input  logic [31:0]                   uc_awaddr_i,
  input  logic [31:0]                   uc_wdata_i,
  input  logic [3:0]                    uc_wstrb_i,
  output logic                          uc_req_accept_o,
  output logic                          uc_bvalid_o,
  input  logic                          drain_i,
  output logic                          drain_done_o,
  output logic                          axi_wen_o,
  output logic [31:0]                   axi_awaddr_o,
  output logic [DCACHELINE_WIDTH-1:0]   axi_wdata_o,
  output logic [DCACHELINE_WIDTH/8-1:0] axi_wstrb_o,
  output logic                          axi_wline_o,
  input  logic                          axi_req_accept_i,
  input  logic                          axi_bvalid_i
);

  localparam int STRB_W   = DCACHELINE_WIDTH / 8;
  localparam int WORDS    = DCACHELINE_WIDTH / 32;
  localparam int STREAK_W = $clog2(MAX_UC_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_UC_STREAK);

  dcache_wr_arb_state_t        r_state;
  wr_owner_t                   r_owner;
  logic [STREAK_W-1:0]         r_streak;
  logic [31:0]                 r_awaddr;
  logic [DCACHELINE_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]           r_wstrb;
  logic                        r_wline;

  logic                        w_idle;
  logic                        w_in_req;
  logic                        w_in_wait_b;
  logic                        w_fifo_grant;
  logic                        w_uc_grant;
  logic [31:0]                 w_fifo_addr;
  logic [STRB_W-1:0]           w_uc_strb;

  assign w_idle      = (r_state == IDLE);
  assign w_in_req    = (r_state == REQ);
  assign w_in_wait_b = (r_state == WAIT_B);

  // FIFO wins when it must make progress (drain, full, streak exhausted)
  // or when the uncached path is not asking at all.
  assign w_fifo_grant = w_idle && fifo_wen_i &&
                        (drain_i || fifo_full_i || !uc_wen_i || (r_streak == STREAK_MAX));
  assign w_uc_grant   = w_idle && !w_fifo_grant && uc_wen_i && !drain_i;

  // Line address is forced onto a line boundary regardless of what the FIFO presents.
  assign w_fifo_addr = fifo_awaddr_i & 32'hFFFF_FFF0;
  // Word strobes land in the byte lanes of the addressed word within the line.
  assign w_uc_strb   = STRB_W'(uc_wstrb_i) << {uc_awaddr_i[3:2], 2'b00};

  // Transaction FSM and request capture register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_owner  <= NONE;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_wline  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_fifo_grant) begin
            r_state  <= REQ;
            r_owner  <= FIFO;
            r_awaddr <= w_fifo_addr;
            r_wdata  <= fifo_wdata_i;
            r_wstrb  <= '1;
            r_wline  <= 1'b1;
          end else if (w_uc_grant) begin
            r_state  <= REQ;
            r_owner  <= UC;
            r_awaddr <= uc_awaddr_i;
            r_wdata  <= {WORDS{uc_wdata_i}};
            r_wstrb  <= w_uc_strb;
            r_wline  <= 1'b0;
          end
        end
        REQ: begin
          // A response arriving before the accept is ignored here.
          if (axi_req_accept_i) r_state <= WAIT_B;
        end
        WAIT_B: begin
          if (axi_bvalid_i) begin
            r_state <= IDLE;
            r_owner <= NONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_owner <= NONE;
        end
      endcase
    end
  end

  // Consecutive uncached grants while the FIFO waits; only moves in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= '0;
    end else if (w_idle) begin
      if (w_fifo_grant || !fifo_wen_i) begin
        r_streak <= '0;
      end else if (w_uc_grant && (r_streak != STREAK_MAX)) begin
        r_streak <= r_streak + STREAK_W'(1);
      end
    end
  end

  assign axi_wen_o    = w_in_req;
  assign axi_awaddr_o = r_awaddr;
  assign axi_wdata_o  = r_wdata;
  assign axi_wstrb_o  = r_wstrb;
  assign axi_wline_o  = r_wline;

  // Handshake pulses are steered to the owner only, in the same cycle as the AXI event.
  assign fifo_req_accept_o = w_in_req    && axi_req_accept_i && (r_owner == FIFO);
  assign uc_req_accept_o   = w_in_req    && axi_req_accept_i && (r_owner == UC);
  assign fifo_bvalid_o     = w_in_wait_b && axi_bvalid_i     && (r_owner == FIFO);
  assign uc_bvalid_o       = w_in_wait_b && axi_bvalid_i     && (r_owner == UC);

  assign drain_done_o = drain_i && fifo_empty_i && w_idle;

endmodule

// File: tb/tb_dcache_wr_arbiter.sv
// Bench for dcache_wr_arbiter: directed scenarios with literal expectations,
// then randomized requesters and AXI responder checked every cycle against
// a transaction-level model of the arbiter.
module tb_dcache_wr_arbiter;

  localparam int LW   = 128;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_wen_i = 1'b0;
  logic [31:0]   fifo_awaddr_i = '0;
  logic [LW-1:0] fifo_wdata_i = '0;
  logic          fifo_full_i = 1'b0;
  logic          fifo_empty_i = 1'b1;
  logic          fifo_req_accept_o, fifo_bvalid_o;
  logic          uc_wen_i = 1'b0;
  logic [31:0]   uc_awaddr_i = '0;
  logic [31:0]   uc_wdata_i = '0;
  logic [3:0]    uc_wstrb_i = '0;
  logic          uc_req_accept_o, uc_bvalid_o;
  logic          drain_i = 1'b0;
  logic          drain_done_o;
  logic          axi_wen_o;
  logic [31:0]   axi_awaddr_o;
  logic [LW-1:0] axi_wdata_o;
  logic [15:0]   axi_wstrb_o;
  logic          axi_wline_o;
  logic          axi_req_accept_i = 1'b0;
  logic          axi_bvalid_i = 1'b0;

  dcache_wr_arbiter #(.DCACHELINE_WIDTH(LW), .MAX_UC_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .fifo_wen_i(fifo_wen_i), .fifo_awaddr_i(fifo_awaddr_i), .fifo_wdata_i(fifo_wdata_i),
    .fifo_full_i(fifo_full_i), .fifo_empty_i(fifo_empty_i),
    .fifo_req_accept_o(fifo_req_accept_o), .fifo_bvalid_o(fifo_bvalid_o),
    .uc_wen_i(uc_wen_i), .uc_awaddr_i(uc_awaddr_i), .uc_wdata_i(uc_wdata_i), .uc_wstrb_i(uc_wstrb_i),
    .uc_req_accept_o(uc_req_accept_o), .uc_bvalid_o(uc_bvalid_o),
    .drain_i(drain_i), .drain_done_o(drain_done_o),
    .axi_wen_o(axi_wen_o), .axi_awaddr_o(axi_awaddr_o), .axi_wdata_o(axi_wdata_o),
    .axi_wstrb_o(axi_wstrb_o), .axi_wline_o(axi_wline_o),
    .axi_req_accept_i(axi_req_accept_i), .axi_bvalid_i(axi_bvalid_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One pending write: is there one, has it been accepted, and its payload.
  bit          m_busy, m_acc, m_line;
  logic [31:0] m_addr;
  logic [LW-1:0] m_data;
  logic [15:0] m_strb;
  int          m_streak;
  logic        mdl_fifo_win, mdl_uc_win;

  function automatic logic [LW-1:0] replicate_word(input logic [31:0] w);
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[32*i +: 32] = w;
    return r;
  endfunction

  function automatic logic [15:0] word_lanes(input logic [3:0] s, input logic [31:0] a);
    int word_idx;
    word_idx = int'(a[3:2]);
    return 16'(s) * 16'(1 << (4 * word_idx));
  endfunction

  assign mdl_fifo_win = fifo_wen_i && (drain_i || fifo_full_i || !uc_wen_i || (m_streak == MAXS));
  assign mdl_uc_win   = !mdl_fifo_win && uc_wen_i && !drain_i;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_acc <= 1'b0; m_line <= 1'b0; m_streak <= 0;
      m_addr <= '0; m_data <= '0; m_strb <= '0;
    end else if (!m_busy) begin
      if (mdl_fifo_win) begin
        m_busy <= 1'b1; m_line <= 1'b1;
        m_addr <= {fifo_awaddr_i[31:4], 4'h0};
        m_data <= fifo_wdata_i; m_strb <= 16'hFFFF;
      end else if (mdl_uc_win) begin
        m_busy <= 1'b1; m_line <= 1'b0;
        m_addr <= uc_awaddr_i;
        m_data <= replicate_word(uc_wdata_i);
        m_strb <= word_lanes(uc_wstrb_i, uc_awaddr_i);
      end
      if (mdl_fifo_win) m_streak <= 0;
      else if (mdl_uc_win && fifo_wen_i) m_streak <= (m_streak < MAXS) ? m_streak + 1 : MAXS;
      else if (!fifo_wen_i) m_streak <= 0;
    end else if (!m_acc) begin
      if (axi_req_accept_i) m_acc <= 1'b1;
    end else if (axi_bvalid_i) begin
      m_busy <= 1'b0; m_acc <= 1'b0;
    end
  end

  logic e_wen, e_fa, e_ua, e_fb, e_ub, e_dd;
  assign e_wen = m_busy && !m_acc;
  assign e_fa  = e_wen && axi_req_accept_i && m_line;
  assign e_ua  = e_wen && axi_req_accept_i && !m_line;
  assign e_fb  = m_busy && m_acc && axi_bvalid_i && m_line;
  assign e_ub  = m_busy && m_acc && axi_bvalid_i && !m_line;
  assign e_dd  = drain_i && fifo_empty_i && !m_busy;

  // ---------------- per-cycle compare + pulse/grant observation ----------------
  int cnt_fa = 0, cnt_fb = 0, cnt_ua = 0, cnt_ub = 0;
  int glog[$];
  logic prev_wen = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      check("axi_wen", axi_wen_o, e_wen);
      check("fifo_req_accept", fifo_req_accept_o, e_fa);
      check("uc_req_accept", uc_req_accept_o, e_ua);
      check("fifo_bvalid", fifo_bvalid_o, e_fb);
      check("uc_bvalid", uc_bvalid_o, e_ub);
      check("drain_done", drain_done_o, e_dd);
      if (e_wen) begin
        check("axi_awaddr", axi_awaddr_o, m_addr);
        check("axi_wdata", axi_wdata_o, m_data);
        check("axi_wstrb", axi_wstrb_o, m_strb);
        check("axi_wline", axi_wline_o, m_line);
      end
      if (fifo_req_accept_o) cnt_fa++;
      if (fifo_bvalid_o) cnt_fb++;
      if (uc_req_accept_o) cnt_ua++;
      if (uc_bvalid_o) cnt_ub++;
      if (axi_wen_o && !prev_wen) glog.push_back(int'(axi_wline_o));
      prev_wen = axi_wen_o;
    end
  end

  // ---------------- AXI responder ----------------
  int acc_fixed = 1, b_fixed = 2;
  bit junk = 1'b0;
  int resp_phase = 0;
  int rst_cnt = 0;

  initial forever begin
    @(posedge rst);
    rst_cnt++;
  end

  initial begin
    int cnt, bcnt, seen_rst;
    cnt = 0; bcnt = 0; seen_rst = 0;
    forever begin
      @(posedge clk); #1;
      axi_req_accept_i = 1'b0;
      axi_bvalid_i     = 1'b0;
      if (rst || rst_cnt != seen_rst) begin
        seen_rst = rst_cnt;
        resp_phase = 0;
      end else if (resp_phase == 3) begin
        resp_phase = 0;
        if (junk) axi_req_accept_i = ($urandom_range(0, 3) == 0);
      end else if (resp_phase == 2) begin
        if (bcnt == 0) begin
          axi_bvalid_i = 1'b1;
          resp_phase = 3;
        end else begin
          bcnt--;
          if (junk) axi_req_accept_i = ($urandom_range(0, 3) == 0);
        end
      end else begin
        if (resp_phase == 0) begin
          if (axi_wen_o) begin
            resp_phase = 1;
            cnt = (acc_fixed >= 0) ? acc_fixed : int'($urandom_range(0, 3));
          end else if (junk) begin
            axi_req_accept_i = ($urandom_range(0, 3) == 0);
            axi_bvalid_i     = ($urandom_range(0, 3) == 0);
          end
        end
        if (resp_phase == 1) begin
          if (junk) axi_bvalid_i = ($urandom_range(0, 2) == 0);
          if (cnt == 0) begin
            axi_req_accept_i = 1'b1;
            resp_phase = 2;
            bcnt = (b_fixed >= 0) ? b_fixed : int'($urandom_range(0, 4));
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (!m_busy && resp_phase == 0) done = 1'b1;
    end
    check(name, done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  localparam logic [LW-1:0] PAT_A = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  int b_fa, b_fb, b_ua, b_ub, gbase, entries, last_fb, last_ua;
  bit done;
  int t3_exp[6] = '{0, 0, 0, 0, 1, 0};

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wen", axi_wen_o, 0);
    check("rst_awaddr", axi_awaddr_o, 0);
    check("rst_wdata", axi_wdata_o, 0);
    check("rst_wstrb", axi_wstrb_o, 0);
    check("rst_wline", axi_wline_o, 0);
    #2 rst = 1'b0;
    tick();

    // T1: FIFO only, address low bits must be masked off
    b_fa = cnt_fa; b_fb = cnt_fb; b_ua = cnt_ua; b_ub = cnt_ub;
    fifo_wen_i = 1'b1; fifo_awaddr_i = 32'h1000_001F; fifo_wdata_i = PAT_A; fifo_empty_i = 1'b0;
    tick();
    fifo_wen_i = 1'b0; fifo_empty_i = 1'b1; fifo_wdata_i = '0; fifo_awaddr_i = '0;
    @(negedge clk);
    check("t1_wen", axi_wen_o, 1);
    check("t1_addr", axi_awaddr_o, 32'h1000_0010);
    check("t1_data", axi_wdata_o, PAT_A);
    check("t1_strb", axi_wstrb_o, 16'hFFFF);
    check("t1_wline", axi_wline_o, 1);
    wait_idle("t1_done", 40);
    check("t1_fifo_acc_n", cnt_fa - b_fa, 1);
    check("t1_fifo_b_n", cnt_fb - b_fb, 1);
    check("t1_uc_n", (cnt_ua - b_ua) + (cnt_ub - b_ub), 0);

    // T2: uncached only, word 2 of the line
    b_fa = cnt_fa; b_fb = cnt_fb; b_ua = cnt_ua; b_ub = cnt_ub;
    uc_wen_i = 1'b1; uc_awaddr_i = 32'h8000_0008; uc_wdata_i = 32'hDEAD_BEEF; uc_wstrb_i = 4'h3;
    tick();
    uc_wen_i = 1'b0; uc_wdata_i = '0; uc_awaddr_i = '0; uc_wstrb_i = '0;
    @(negedge clk);
    check("t2_addr", axi_awaddr_o, 32'h8000_0008);
    check("t2_data", axi_wdata_o, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
    check("t2_strb", axi_wstrb_o, 16'h0300);
    check("t2_wline", axi_wline_o, 0);
    wait_idle("t2_done", 40);
    check("t2_uc_acc_n", cnt_ua - b_ua, 1);
    check("t2_uc_b_n", cnt_ub - b_ub, 1);
    check("t2_fifo_n", (cnt_fa - b_fa) + (cnt_fb - b_fb), 0);

    // T3: both requesting continuously -> UC x4 then FIFO then UC
    gbase = glog.size();
    fifo_wen_i = 1'b1; fifo_empty_i = 1'b0; fifo_awaddr_i = 32'h2000_0040; fifo_wdata_i = PAT_A;
    uc_wen_i = 1'b1; uc_awaddr_i = 32'h9000_0004; uc_wdata_i = 32'h1234_5678; uc_wstrb_i = 4'hF;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (glog.size() >= gbase + 6) done = 1'b1;
    end
    fifo_wen_i = 1'b0; fifo_empty_i = 1'b1; uc_wen_i = 1'b0;
    check("t3_six_grants", done, 1);
    for (int i = 0; i < 6; i++)
      check($sformatf("t3_grant%0d_wline", i), (glog.size() > gbase + i) ? glog[gbase + i] : -1, t3_exp[i]);
    wait_idle("t3_done", 40);

    // T4: FIFO full beats a pending uncached request
    gbase = glog.size();
    fifo_wen_i = 1'b1; fifo_full_i = 1'b1; fifo_empty_i = 1'b0; uc_wen_i = 1'b1;
    tick();
    fifo_wen_i = 1'b0; fifo_full_i = 1'b0; fifo_empty_i = 1'b1; uc_wen_i = 1'b0;
    @(negedge clk);
    check("t4_first_is_fifo", (glog.size() > gbase) ? glog[gbase] : -1, 1);
    wait_idle("t4_done", 40);

    // T5: drain with two FIFO entries and an uncached request waiting
    b_fa = cnt_fa; b_fb = cnt_fb; b_ua = cnt_ua; b_ub = cnt_ub;
    drain_i = 1'b1; entries = 2; last_fb = cnt_fb;
    fifo_wen_i = 1'b1; fifo_empty_i = 1'b0;
    uc_wen_i = 1'b1; uc_awaddr_i = 32'hA000_000C; uc_wdata_i = 32'hCAFE_F00D; uc_wstrb_i = 4'h1;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      if (cnt_fb != last_fb) begin
        last_fb = cnt_fb;
        entries--;
        if (entries == 0) begin fifo_wen_i = 1'b0; fifo_empty_i = 1'b1; end
      end
      if (entries == 0 && !m_busy) done = 1'b1;
    end
    check("t5_flushed", done, 1);
    @(negedge clk);
    check("t5_drain_done", drain_done_o, 1);
    check("t5_fifo_b_n", cnt_fb - b_fb, 2);
    check("t5_no_uc_grant", cnt_ua - b_ua, 0);
    tick();
    drain_i = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      tick();
      if (cnt_ua != b_ua) begin done = 1'b1; uc_wen_i = 1'b0; end
    end
    check("t5_uc_after_drain", done, 1);
    uc_wen_i = 1'b0;
    wait_idle("t5_done", 40);

    // T6: reset while waiting for the write response
    acc_fixed = 0; b_fixed = 20;
    fifo_wen_i = 1'b1; fifo_empty_i = 1'b0; fifo_awaddr_i = 32'h3000_0080; fifo_wdata_i = ~PAT_A;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (m_busy && m_acc) done = 1'b1;
    end
    check("t6_in_wait_b", done, 1);
    tick();
    b_fa = cnt_fa; b_fb = cnt_fb; b_ua = cnt_ua; b_ub = cnt_ub;
    gbase = glog.size();
    #2 rst = 1'b1;
    #1;
    check("t6_async_addr", axi_awaddr_o, 0);
    check("t6_async_data", axi_wdata_o, 0);
    check("t6_async_wline", axi_wline_o, 0);
    b_fixed = 2;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    check("t6_no_bvalid", (cnt_fb - b_fb) + (cnt_ub - b_ub), 0);
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (glog.size() > gbase) done = 1'b1;
    end
    fifo_wen_i = 1'b0; fifo_empty_i = 1'b1;
    check("t6_regrant", done, 1);
    check("t6_regrant_is_fifo", (glog.size() > gbase) ? glog[gbase] : -1, 1);
    wait_idle("t6_done", 40);
    check("t6_fifo_b_after", cnt_fb - b_fb, 1);

    // Randomized traffic: requesters, drain and reset pulses all random
    acc_fixed = -1; b_fixed = -1; junk = 1'b1;
    entries = 0; last_fb = cnt_fb; last_ua = cnt_ua;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (cnt_fb != last_fb) begin
        last_fb = cnt_fb;
        if ($urandom_range(0, 3) != 0 && entries > 0) entries--;
      end
      if (entries < 4 && $urandom_range(0, 5) == 0) entries++;
      fifo_wen_i    = (entries > 0);
      fifo_full_i   = (entries == 4);
      fifo_empty_i  = (entries == 0);
      fifo_awaddr_i = $urandom;
      fifo_wdata_i  = {$urandom, $urandom, $urandom, $urandom};
      if (cnt_ua != last_ua) begin
        last_ua = cnt_ua;
        uc_wen_i = 1'b0;
      end else if (!uc_wen_i && $urandom_range(0, 3) == 0) begin
        uc_wen_i = 1'b1;
      end
      uc_awaddr_i = $urandom;
      uc_wdata_i  = $urandom;
      uc_wstrb_i  = 4'($urandom);
      if ($urandom_range(0, 39) == 0) drain_i = ~drain_i;
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1;
        #4 rst = 1'b0;
      end
    end
    fifo_wen_i = 1'b0; fifo_full_i = 1'b0; fifo_empty_i = 1'b1;
    uc_wen_i = 1'b0; drain_i = 1'b0; junk = 1'b0;
    wait_idle("random_quiesce", 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
